// File: rtl/muldiv_sequencer_pkg.sv
// Shared constants and state type for the iterative multiply/divide unit.
package muldiv_pkg;

   localparam logic [5:0] FUNCT_MULT  = 6'b011000;
   localparam logic [5:0] FUNCT_MULTU = 6'b011001;
   localparam logic [5:0] FUNCT_DIV   = 6'b011010;
   localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

   localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RUN,
      FIXUP,
      DONE
   } muldiv_state_t;

   function automatic logic funct_legal(logic [5:0] f);
      return f inside {FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU};
   endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Execute-stage request/result bundle for the multiply/divide unit.
interface muldiv_sequencer_if #(
   parameter int WIDTH = 32
);

   logic             start;
   logic [5:0]       funct;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] operand_b;
   logic             flush;
   logic             hi_lo_access;
   logic             busy;
   logic             stall;
   logic [WIDTH-1:0] HI_result;
   logic [WIDTH-1:0] LO_result;
   logic             HI_LO_write;

   modport master (
      output start, funct, operand_a, operand_b, flush, hi_lo_access,
      input  busy, stall, HI_result, LO_result, HI_LO_write
   );

   modport slave (
      input  start, funct, operand_a, operand_b, flush, hi_lo_access,
      output busy, stall, HI_result, LO_result, HI_LO_write
   );

endinterface

// File: rtl/muldiv_sequencer_twos_comp_abs.sv
// Conditional two's-complement negate, used for operand abs and result sign fixup.
module twos_comp_abs #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] in_i,
   input  logic             negate_en_i,
   output logic [WIDTH-1:0] out_o
);

   assign out_o = negate_en_i ? -in_i : in_i;

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO write port.
// Optional MULDIV_EARLY_TERM_EN: multiply leaves RUN once remaining multiplier bits are zero.
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int ITER  = 32
) (
   input logic               clk,
   input logic               reset_n,
   muldiv_sequencer_if.slave bus
);

   localparam int CW = $clog2(ITER);
   localparam int PW = 2 * WIDTH;

   muldiv_state_t    state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             is_div_q, is_div_d;
   logic             is_sgn_q, is_sgn_d;
   logic             sgn_q, sgn_d;
   logic             rsgn_q, rsgn_d;
   logic [PW-1:0]    prod_q, prod_d;
   logic [PW-1:0]    mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH:0]   rem_q, rem_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   logic [WIDTH-1:0] abs_a, abs_b;
   logic [WIDTH-1:0] quo_fix, rem_fix;
   logic [PW-1:0]    prod_fix;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH+1:0] diff;
   logic             busy;

   twos_comp_abs #(.WIDTH(WIDTH)) u_abs_a (
      .in_i(a_q), .negate_en_i(is_sgn_q & a_q[WIDTH-1]), .out_o(abs_a)
   );
   twos_comp_abs #(.WIDTH(WIDTH)) u_abs_b (
      .in_i(b_q), .negate_en_i(is_sgn_q & b_q[WIDTH-1]), .out_o(abs_b)
   );
   twos_comp_abs #(.WIDTH(PW)) u_neg_prod (
      .in_i(prod_q), .negate_en_i(sgn_q), .out_o(prod_fix)
   );
   twos_comp_abs #(.WIDTH(WIDTH)) u_neg_quo (
      .in_i(mplier_q), .negate_en_i(sgn_q), .out_o(quo_fix)
   );
   twos_comp_abs #(.WIDTH(WIDTH)) u_neg_rem (
      .in_i(rem_q[WIDTH-1:0]), .negate_en_i(rsgn_q), .out_o(rem_fix)
   );

   // Restoring step: mplier_q doubles as dividend/quotient shift register.
   assign rem_sh = {rem_q[WIDTH-1:0], mplier_q[WIDTH-1]};
   assign diff   = {rem_q, mplier_q[WIDTH-1]} - {2'b00, mcand_q[WIDTH-1:0]};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      is_div_d = is_div_q;
      is_sgn_d = is_sgn_q;
      sgn_d    = sgn_q;
      rsgn_d   = rsgn_q;
      prod_d   = prod_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      rem_d    = rem_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start && funct_legal(bus.funct)) begin
               a_d      = bus.operand_a;
               b_d      = bus.operand_b;
               is_div_d = (bus.funct == FUNCT_DIV) || (bus.funct == FUNCT_DIVU);
               is_sgn_d = (bus.funct == FUNCT_MULT) || (bus.funct == FUNCT_DIV);
               state_d  = LOAD;
            end
         end
         LOAD: begin
            sgn_d    = is_sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
            rsgn_d   = is_sgn_q & a_q[WIDTH-1];
            mcand_d  = {{WIDTH{1'b0}}, (is_div_q ? abs_b : abs_a)};
            mplier_d = is_div_q ? abs_a : abs_b;
            prod_d   = '0;
            rem_d    = '0;
            cnt_d    = '0;
            state_d  = RUN;
         end
         RUN: begin
            cnt_d = cnt_q + CW'(1);
            if (is_div_q) begin
               if (diff[WIDTH+1]) begin
                  rem_d    = rem_sh;
                  mplier_d = {mplier_q[WIDTH-2:0], 1'b0};
               end else begin
                  rem_d    = diff[WIDTH:0];
                  mplier_d = {mplier_q[WIDTH-2:0], 1'b1};
               end
            end else begin
               if (mplier_q[0]) prod_d = prod_q + mcand_q;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
            end
            if (cnt_q == CW'(ITER - 1)) state_d = FIXUP;
`ifdef MULDIV_EARLY_TERM_EN
            if (!is_div_q && (mplier_q == '0)) state_d = FIXUP;
`else
`endif
         end
         FIXUP: begin
            if (!is_div_q) begin
               {hi_d, lo_d} = prod_fix;
            end else if (b_q == '0) begin
               hi_d = a_q;
               lo_d = WIDTH'(DIV0_LO);
            end else begin
               hi_d = rem_fix;
               lo_d = quo_fix;
            end
            state_d = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Cancelled ops must leave HI/LO untouched.
      if (bus.flush && (state_q != IDLE)) begin
         state_d = IDLE;
         hi_d    = hi_q;
         lo_d    = lo_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         is_div_q <= 1'b0;
         is_sgn_q <= 1'b0;
         sgn_q    <= 1'b0;
         rsgn_q   <= 1'b0;
         prod_q   <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         rem_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         is_div_q <= is_div_d;
         is_sgn_q <= is_sgn_d;
         sgn_q    <= sgn_d;
         rsgn_q   <= rsgn_d;
         prod_q   <= prod_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         rem_q    <= rem_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign busy            = (state_q != IDLE);
   assign bus.busy        = busy;
   assign bus.stall       = busy & bus.hi_lo_access;
   assign bus.HI_result   = hi_q;
   assign bus.LO_result   = lo_q;
   assign bus.HI_LO_write = (state_q == DONE) & ~bus.flush;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed corner cases plus random ops.
module tb_muldiv_sequencer;
   import muldiv_pkg::*;

`ifdef MULDIV_EARLY_TERM_EN
   localparam int MUL_LAT = 0;
`else
   localparam int MUL_LAT = 35;
`endif

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   muldiv_sequencer_if #(.WIDTH(32)) bus ();

   muldiv_sequencer #(.WIDTH(32), .ITER(32)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus.slave)
   );

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int nchk = 0;
   int nerr = 0;
   int cyc = 0;
   int nwr = 0;
   int wcyc = 0;
   int s_cyc = 0;
   logic [5:0] ftab [4];

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] model(logic [5:0] f, logic [31:0] a,
                                         logic [31:0] b);
      logic signed [63:0] sp;
      logic [31:0] q, r;
      if (f == FUNCT_MULTU) return {32'b0, a} * {32'b0, b};
      if (f == FUNCT_MULT) begin
         sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
         return sp;
      end
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (f == FUNCT_DIVU) return {a % b, a / b};
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      return {r, q};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      exp_t e;
      if (reset_n && bus.HI_LO_write) begin
         nwr  <= nwr + 1;
         wcyc <= cyc;
         if (sb.size() == 0) begin
            chk("spurious_wr", {63'b0, bus.HI_LO_write}, 64'd0);
         end else begin
            e = sb.pop_front();
            chk({e.tag, "_hi"}, {32'b0, bus.HI_result}, {32'b0, e.hi});
            chk({e.tag, "_lo"}, {32'b0, bus.LO_result}, {32'b0, e.lo});
         end
      end
   end

   task automatic push_exp(string tag, logic [31:0] hi, logic [31:0] lo);
      exp_t e;
      e.hi  = hi;
      e.lo  = lo;
      e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic issue(logic [5:0] f, logic [31:0] a, logic [31:0] b);
      @(posedge clk); #1;
      bus.funct     = f;
      bus.operand_a = a;
      bus.operand_b = b;
      bus.start     = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      s_cyc     = cyc;
   endtask

   task automatic await_wr(string tag, int lat);
      int n0;
      n0 = nwr;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk); #1;
         if (nwr != n0) break;
      end
      if (nwr == n0) begin
         chk({tag, "_timeout"}, 64'd0, 64'd1);
      end else begin
         if (lat != 0) chk({tag, "_lat"}, 64'(wcyc - s_cyc + 1), 64'(lat));
         @(negedge clk);
         chk({tag, "_pulse"}, {63'b0, bus.HI_LO_write}, 64'd0);
      end
   endtask

   task automatic run_op(string tag, logic [5:0] f, logic [31:0] a,
                         logic [31:0] b, logic [31:0] hi, logic [31:0] lo,
                         int lat);
      push_exp(tag, hi, lo);
      issue(f, a, b);
      await_wr(tag, lat);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [63:0] m;
      logic [5:0]  f;
      logic [31:0] a, b;
      int          n0;
      ftab[0] = FUNCT_MULT;
      ftab[1] = FUNCT_MULTU;
      ftab[2] = FUNCT_DIV;
      ftab[3] = FUNCT_DIVU;
      bus.start        = 1'b0;
      bus.funct        = 6'd0;
      bus.operand_a    = 32'd0;
      bus.operand_b    = 32'd0;
      bus.flush        = 1'b0;
      bus.hi_lo_access = 1'b1;

      repeat (2) @(negedge clk);
      chk("rst_busy", {63'b0, bus.busy}, 64'd0);
      chk("rst_stall", {63'b0, bus.stall}, 64'd0);
      chk("rst_wr", {63'b0, bus.HI_LO_write}, 64'd0);
      chk("rst_hi", {32'b0, bus.HI_result}, 64'd0);
      chk("rst_lo", {32'b0, bus.LO_result}, 64'd0);
      bus.hi_lo_access = 1'b0;
      reset_n = 1'b1;

      run_op("multu_max", FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             32'hFFFF_FFFE, 32'h0000_0001, 35);
      run_op("mult_neg", FUNCT_MULT, -32'sd7, 32'd3,
             32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_LAT);
      run_op("div_neg", FUNCT_DIV, -32'sd7, 32'd2,
             32'hFFFF_FFFF, 32'hFFFF_FFFD, 35);
      run_op("divu_by0", FUNCT_DIVU, 32'd100, 32'd0,
             32'd100, 32'hFFFF_FFFF, 35);
      run_op("div_ovf", FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
             32'h0, 32'h8000_0000, 35);
      run_op("div_by0_s", FUNCT_DIV, -32'sd7, 32'd0,
             32'hFFFF_FFF9, 32'hFFFF_FFFF, 35);

      // illegal funct is ignored
      @(posedge clk); #1;
      bus.funct = 6'b100000;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(negedge clk);
      chk("illegal_busy", {63'b0, bus.busy}, 64'd0);

      // flush in RUN iteration 10, then immediate DIVU
      issue(FUNCT_MULTU, 32'd6, 32'd7);
      repeat (11) @(posedge clk);
      #1;
      bus.flush = 1'b1;
      @(negedge clk);
      chk("flush_busy_pre", {63'b0, bus.busy}, 64'd1);
      @(posedge clk); #1;
      bus.flush = 1'b0;
      push_exp("divu_after_flush", 32'd1, 32'd2);
      bus.funct     = FUNCT_DIVU;
      bus.operand_a = 32'd9;
      bus.operand_b = 32'd4;
      bus.start     = 1'b1;
      @(negedge clk);
      chk("flush_busy", {63'b0, bus.busy}, 64'd0);
      @(posedge clk); #1;
      bus.start = 1'b0;
      s_cyc     = cyc;
      await_wr("divu_after_flush", 35);

      // stall window plus ignored start during RUN
      push_exp("div_stall", 32'd2, 32'hFFFF_FFF2);
      bus.hi_lo_access = 1'b1;
      n0 = nwr;
      issue(FUNCT_DIV, 32'd100, 32'hFFFF_FFF9);
      for (int k = 0; k < 37; k++) begin
         @(negedge clk);
         chk($sformatf("stall_c%0d", k), {63'b0, bus.stall},
             64'(cyc <= s_cyc + 34));
         @(posedge clk); #1;
         bus.start = (k == 9);
      end
      bus.start        = 1'b0;
      bus.hi_lo_access = 1'b0;
      chk("single_wr", 64'(nwr - n0), 64'd1);

      // flush coinciding with DONE suppresses the write
      issue(FUNCT_DIVU, 32'd30, 32'd4);
      repeat (34) @(posedge clk);
      #1;
      bus.flush = 1'b1;
      @(negedge clk);
      chk("flush_done_wr", {63'b0, bus.HI_LO_write}, 64'd0);
      @(posedge clk); #1;
      bus.flush = 1'b0;
      @(negedge clk);
      chk("flush_done_busy", {63'b0, bus.busy}, 64'd0);

      // flush and start together in IDLE: start wins
      push_exp("flush_start_idle", 32'd0, 32'd42);
      @(posedge clk); #1;
      bus.funct     = FUNCT_MULTU;
      bus.operand_a = 32'd6;
      bus.operand_b = 32'd7;
      bus.start     = 1'b1;
      bus.flush     = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.flush = 1'b0;
      s_cyc     = cyc;
      await_wr("flush_start_idle", MUL_LAT);

      // async reset during FIXUP
      issue(FUNCT_DIVU, 32'd50, 32'd3);
      repeat (33) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      chk("rst_mid_busy", {63'b0, bus.busy}, 64'd0);
      chk("rst_mid_hi", {32'b0, bus.HI_result}, 64'd0);
      chk("rst_mid_lo", {32'b0, bus.LO_result}, 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("rst_mid_idle", {63'b0, bus.busy}, 64'd0);

`ifdef MULDIV_EARLY_TERM_EN
      run_op("et_5x1", FUNCT_MULTU, 32'd5, 32'd1, 32'd0, 32'd5, 0);
      chk("et_5x1_le5", 64'((wcyc - s_cyc + 1) <= 5), 64'd1);
      run_op("et_x0", FUNCT_MULTU, 32'd123, 32'd0, 32'd0, 32'd0, 4);
`else
`endif

      for (int i = 0; i < 8; i++) begin
         f = ftab[$urandom_range(0, 3)];
         a = $urandom;
         b = (i % 3 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
         m = model(f, a, b);
         run_op($sformatf("rnd%0d", i), f, a, b, m[63:32], m[31:0],
                f[1] ? 35 : MUL_LAT);
      end

      repeat (3) @(negedge clk);
      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
